// File: rtl/blackjack_deal_sequencer_if.sv
// Card-source handshake: one request pulse from the sequencer, one valid-qualified card back.
interface blackjack_deal_sequencer_if;
    logic       card_req_o;
    logic       card_valid_i;
    logic [7:0] card_i;

    modport master (output card_req_o, input card_valid_i, input card_i);
    modport slave  (input card_req_o, output card_valid_i, output card_i);
endinterface

// File: rtl/blackjack_deal_sequencer.sv
// Blackjack round controller: deals the opening hands, serves hit/stand, plays the dealer and resolves.
module blackjack_deal_sequencer #(
    parameter int DECK_SIZE    = 52,
    parameter int DEALER_STAND = 17,
    parameter int CARD_TIMEOUT = 15
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              hit_i,
    input  logic                              stand_i,
    blackjack_deal_sequencer_if.master        card_bus,
    output logic [7:0]                        player_card_o,
    output logic                              player_card_we_o,
    output logic [7:0]                        dealer_card_o,
    output logic                              dealer_card_we_o,
    output logic [4:0]                        player_total_o,
    output logic [4:0]                        dealer_total_o,
    output logic                              player_soft_o,
    output logic [5:0]                        cards_dealt_o,
    output logic [1:0]                        result_o,
    output logic                              done_o,
    output logic                              error_o
);

    localparam int              TW           = $clog2(CARD_TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(CARD_TIMEOUT - 1);
    localparam logic [5:0]      DECK_LAST    = 6'(DECK_SIZE);
    localparam logic [4:0]      STAND_TOTAL  = 5'(DEALER_STAND);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_ROUTE, S_PLAYER, S_DEALER, S_RESOLVE, S_DONE
    } state_t;

    state_t        state, state_next;
    logic          target_dealer;
    logic [2:0]    deal_idx;
    logic [7:0]    card_q;
    logic [4:0]    player_hard, dealer_hard;
    logic          player_ace, dealer_ace;
    logic [7:0]    player_card_q, dealer_card_q;
    logic [5:0]    cards_dealt;
    logic [1:0]    result_q;
    logic          error_q;
    logic [TW-1:0] wait_cnt;

    logic start_round, set_error, latch_card, hit_go, draw_go;
    logic [4:0] player_best, dealer_best, route_hard, route_best;
    logic [4:0] route_player_best, route_dealer_best;
    logic       route_ace;

    function automatic logic [4:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 5'd10 : {1'b0, rank};
    endfunction

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[5] ? 5'd31 : s[4:0];
    endfunction

    // An Ace counts as 11 only while that keeps the hand at or below 21.
    function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    assign player_best       = best_total(player_hard, player_ace);
    assign dealer_best       = best_total(dealer_hard, dealer_ace);
    assign route_hard        = sat_add(target_dealer ? dealer_hard : player_hard, card_value(card_q[3:0]));
    assign route_ace         = (target_dealer ? dealer_ace : player_ace) | (card_q[3:0] == 4'd1);
    assign route_best        = best_total(route_hard, route_ace);
    assign route_player_best = target_dealer ? player_best : route_best;
    assign route_dealer_best = target_dealer ? route_best : dealer_best;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        start_round = 1'b0;
        set_error   = 1'b0;
        latch_card  = 1'b0;
        hit_go      = 1'b0;
        draw_go     = 1'b0;
        card_bus.card_req_o = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i && !error_q) begin
                    start_round = 1'b1;
                    state_next  = S_REQ;
                end
            end
            S_REQ: begin
                if (cards_dealt == DECK_LAST) begin
                    set_error  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    card_bus.card_req_o = 1'b1;
                    state_next          = S_WAIT;
                end
            end
            S_WAIT: begin
                if (card_bus.card_valid_i) begin
                    latch_card = 1'b1;
                    state_next = S_ROUTE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    set_error  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_ROUTE: begin
                if (deal_idx < 3'd3) begin
                    state_next = S_REQ;
                end else if (deal_idx == 3'd3) begin
                    state_next = (route_player_best == 5'd21 || route_dealer_best == 5'd21)
                                 ? S_RESOLVE : S_PLAYER;
                end else if (!target_dealer) begin
                    if (route_best > 5'd21)       state_next = S_RESOLVE;
                    else if (route_best == 5'd21) state_next = S_DEALER;
                    else                          state_next = S_PLAYER;
                end else begin
                    state_next = S_DEALER;
                end
            end
            S_PLAYER: begin
                if (stand_i) begin
                    state_next = S_DEALER;
                end else if (hit_i) begin
                    hit_go     = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DEALER: begin
                if (dealer_best < STAND_TOTAL) begin
                    draw_go    = 1'b1;
                    state_next = S_REQ;
                end else begin
                    state_next = S_RESOLVE;
                end
            end
            S_RESOLVE: state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            target_dealer <= 1'b0;
            deal_idx      <= '0;
            card_q        <= '0;
            player_hard   <= '0;
            dealer_hard   <= '0;
            player_ace    <= 1'b0;
            dealer_ace    <= 1'b0;
            player_card_q <= '0;
            dealer_card_q <= '0;
            cards_dealt   <= '0;
            result_q      <= '0;
            error_q       <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            if (start_round) begin
                target_dealer <= 1'b0;
                deal_idx      <= '0;
                player_hard   <= '0;
                dealer_hard   <= '0;
                player_ace    <= 1'b0;
                dealer_ace    <= 1'b0;
                result_q      <= '0;
            end
            if (set_error) error_q <= 1'b1;
            if (state == S_REQ)  wait_cnt <= '0;
            if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (latch_card) begin
                card_q      <= card_bus.card_i;
                cards_dealt <= cards_dealt + 6'd1;
            end
            if (state == S_ROUTE) begin
                if (target_dealer) begin
                    dealer_hard   <= route_hard;
                    dealer_ace    <= route_ace;
                    dealer_card_q <= card_q;
                end else begin
                    player_hard   <= route_hard;
                    player_ace    <= route_ace;
                    player_card_q <= card_q;
                end
                // Opening deal alternates player, dealer, player, dealer.
                if (deal_idx < 3'd4) begin
                    deal_idx      <= deal_idx + 3'd1;
                    target_dealer <= ~deal_idx[0];
                end
            end
            if (hit_go)  target_dealer <= 1'b0;
            if (draw_go) target_dealer <= 1'b1;
            if (state == S_RESOLVE) begin
                if (player_best > 5'd21)          result_q <= 2'b10;
                else if (dealer_best > 5'd21)     result_q <= 2'b01;
                else if (player_best > dealer_best) result_q <= 2'b01;
                else if (dealer_best > player_best) result_q <= 2'b10;
                else                              result_q <= 2'b11;
            end
        end
    end

    assign player_card_o    = player_card_q;
    assign dealer_card_o    = dealer_card_q;
    assign player_card_we_o = (state == S_ROUTE) && !target_dealer;
    assign dealer_card_we_o = (state == S_ROUTE) && target_dealer;
    assign player_total_o   = player_best;
    assign dealer_total_o   = dealer_best;
    assign player_soft_o    = player_ace && (player_hard <= 5'd11);
    assign cards_dealt_o    = cards_dealt;
    assign result_o         = result_q;
    assign done_o           = (state == S_DONE);
    assign error_o          = error_q;

endmodule
